// File: rtl/thermo_pkg.sv
// Shared types, widths, default temperature limits and saturating helpers
// for the thermostat setpoint path.
package thermo_pkg;

  localparam int TEMP_W = 7;

  localparam logic [TEMP_W-1:0] T_MIN_DEF     = 7'd50;
  localparam logic [TEMP_W-1:0] T_MAX_DEF     = 7'd90;
  localparam logic [TEMP_W-1:0] T_DEFAULT_DEF = 7'd70;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EDIT = 1'b1
  } state_e;

  // Increment that sticks at lim; compare first so the add can never wrap.
  function automatic logic [TEMP_W-1:0] sat_inc(input logic [TEMP_W-1:0] v,
                                                input logic [TEMP_W-1:0] lim);
    if (v >= lim) begin
      return lim;
    end else begin
      return v + TEMP_W'(1);
    end
  endfunction

  // Decrement that sticks at lim; compare first so the subtract can never wrap.
  function automatic logic [TEMP_W-1:0] sat_dec(input logic [TEMP_W-1:0] v,
                                                input logic [TEMP_W-1:0] lim);
    if (v <= lim) begin
      return lim;
    end else begin
      return v - TEMP_W'(1);
    end
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One front-panel button: 2-FF synchroniser, stable-count debouncer,
// rising-edge press pulse and the debounced (held) level.
module btn_conditioner #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o,
  output logic level_o
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             deb_q;
  logic             deb_d;
  logic             deb_dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Debounce: count while the synchronised level disagrees, flip on reaching DB_CYCLES.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    if (sync2_q != deb_q) begin
      if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
        deb_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Synchroniser, debounce state and edge-detect flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
    end
  end

  assign press_o = deb_q & ~deb_dly_q;
  assign level_o = deb_q;

endmodule

// File: rtl/setpoint_ctrl.sv
// Front-panel setpoint controller: conditions up/down/set buttons, generates
// auto-repeat steps and runs the edit session that commits a clamped setpoint.
module setpoint_ctrl
  import thermo_pkg::*;
#(
  parameter int                DB_CYCLES    = 4,
  parameter int                REPEAT_DELAY = 20,
  parameter int                REPEAT_RATE  = 5,
  parameter int                TIMEOUT      = 100,
  parameter logic [TEMP_W-1:0] T_MIN        = T_MIN_DEF,
  parameter logic [TEMP_W-1:0] T_MAX        = T_MAX_DEF,
  parameter logic [TEMP_W-1:0] T_DEFAULT    = T_DEFAULT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_set,
  output logic [TEMP_W-1:0] desired_temp,
  output logic              temp_set,
  output logic [TEMP_W-1:0] pending_temp,
  output logic              editing
);

  localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  logic up_press, up_level, dn_press, dn_level, set_press, set_level_unused;

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_up (
    .clk(clk), .reset(reset), .btn_i(btn_up), .press_o(up_press), .level_o(up_level)
  );
  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_down (
    .clk(clk), .reset(reset), .btn_i(btn_down), .press_o(dn_press), .level_o(dn_level)
  );
  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_btn_set (
    .clk(clk), .reset(reset), .btn_i(btn_set), .press_o(set_press), .level_o(set_level_unused)
  );

  logic [HOLD_W-1:0] up_hold_q, up_hold_d, dn_hold_q, dn_hold_d;
  logic [TO_W-1:0]   to_q, to_d;
  state_e            state_q, state_d;
  logic [TEMP_W-1:0] pend_q, pend_d, des_q, des_d;
  logic              tset_q, tset_d;

  logic up_rep, dn_rep, up_step, dn_step, both_step, inc_step, dec_step;

  // A held button repeats each time its hold counter lands on REPEAT_DELAY.
  assign up_rep    = up_level & (up_hold_q == HOLD_W'(REPEAT_DELAY));
  assign dn_rep    = dn_level & (dn_hold_q == HOLD_W'(REPEAT_DELAY));
  assign up_step   = up_press | up_rep;
  assign dn_step   = dn_press | dn_rep;
  assign both_step = up_step & dn_step;
  assign inc_step  = up_step & ~dn_step;
  assign dec_step  = dn_step & ~up_step;

  // Hold counters: run while held; after a repeat, rewind so the next lands REPEAT_RATE later.
  always_comb begin
    up_hold_d = '0;
    dn_hold_d = '0;
    if (!up_level || both_step) begin
      up_hold_d = '0;
    end else if (up_rep) begin
      up_hold_d = HOLD_W'(REPEAT_DELAY - REPEAT_RATE + 1);
    end else begin
      up_hold_d = up_hold_q + HOLD_W'(1);
    end
    if (!dn_level || both_step) begin
      dn_hold_d = '0;
    end else if (dn_rep) begin
      dn_hold_d = HOLD_W'(REPEAT_DELAY - REPEAT_RATE + 1);
    end else begin
      dn_hold_d = dn_hold_q + HOLD_W'(1);
    end
  end

  // Edit-session FSM: next state, pending/committed values and timeout count.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    des_d   = des_q;
    tset_d  = tset_q;
    to_d    = '0;
    case (state_q)
      ST_IDLE: begin
        if (set_press) begin
          tset_d = ~tset_q;
        end else if (inc_step) begin
          pend_d  = sat_inc(des_q, T_MAX);
          state_d = ST_EDIT;
        end else if (dec_step) begin
          pend_d  = sat_dec(des_q, T_MIN);
          state_d = ST_EDIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EDIT: begin
        if (set_press) begin
          // Commit; a same-cycle up/down step is deliberately dropped.
          des_d   = pend_q;
          tset_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (inc_step) begin
          pend_d = sat_inc(pend_q, T_MAX);
        end else if (dec_step) begin
          pend_d = sat_dec(pend_q, T_MIN);
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          pend_d  = des_q;
          state_d = ST_IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: begin
        pend_d  = des_q;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any edit in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pend_q    <= T_DEFAULT;
      des_q     <= T_DEFAULT;
      tset_q    <= 1'b0;
      to_q      <= '0;
      up_hold_q <= '0;
      dn_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      des_q     <= des_d;
      tset_q    <= tset_d;
      to_q      <= to_d;
      up_hold_q <= up_hold_d;
      dn_hold_q <= dn_hold_d;
    end
  end

  assign desired_temp = des_q;
  assign temp_set     = tset_q;
  assign pending_temp = pend_q;
  assign editing      = (state_q == ST_EDIT);

endmodule

// File: tb/tb_setpoint_ctrl.sv
// Directed scenarios followed by randomized button sessions, checked against
// a transaction-level model of the setpoint rules.
module tb_setpoint_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_set = 1'b0;
  logic [6:0] desired_temp;
  logic       temp_set;
  logic [6:0] pending_temp;
  logic       editing;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model state
  int m_pend, m_des, m_tset, m_edit;

  setpoint_ctrl dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_set(btn_set),
    .desired_temp(desired_temp), .temp_set(temp_set),
    .pending_temp(pending_temp), .editing(editing)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int ep, input int ed, input int es, input int ee);
    chk({tag, ".pending"}, int'(pending_temp), ep);
    chk({tag, ".desired"}, int'(desired_temp), ed);
    chk({tag, ".temp_set"}, int'(temp_set), es);
    chk({tag, ".editing"}, int'(editing), ee);
  endtask

  // Hold the chosen buttons for len clocks, release, then let debouncers settle.
  task automatic press(input bit u, input bit d, input bit s, input int len);
    btn_up = u; btn_down = d; btn_set = s;
    repeat (len) tick();
    btn_up = 1'b0; btn_down = 1'b0; btn_set = 1'b0;
    repeat (12) tick();
  endtask

  // Model: one effective up (+1) or down (-1) step.
  task automatic m_step(input int dir);
    int base;
    base = m_edit ? m_pend : m_des;
    base = base + dir;
    if (base > 90) base = 90;
    if (base < 50) base = 50;
    m_pend = base;
    m_edit = 1;
  endtask

  // Model: a clean set press.
  task automatic m_set();
    if (m_edit != 0) begin
      m_des = m_pend; m_tset = 1; m_edit = 0;
    end else begin
      m_tset = 1 - m_tset;
    end
  endtask

  // Steps produced by one clean hold of len clocks: the press plus auto-repeats.
  function automatic int steps_for(input int len);
    if (len >= 21) return 2 + (len - 21) / 5;
    return 1;
  endfunction

  initial begin
    int op, len, n;

    // 1. reset values
    repeat (2) tick();
    reset = 1'b0;
    chk_all("reset", 70, 70, 0, 0);

    // 2. latency of a first press, then commit
    btn_up = 1'b1;
    repeat (6) tick();
    chk_all("lat6", 70, 70, 0, 0);
    tick();
    chk_all("lat7", 71, 70, 0, 1);
    tick();
    btn_up = 1'b0;
    repeat (10) tick();
    press(0, 0, 1, 8);
    chk_all("commit71", 71, 71, 1, 0);

    // 3. short glitches produce nothing
    for (int i = 0; i < 5; i++) begin
      btn_up = 1'b1; repeat (3) tick();
      btn_up = 1'b0; repeat (3) tick();
    end
    repeat (10) tick();
    chk_all("glitch", 71, 71, 1, 0);

    // 4. commit 88, then long hold saturates at 90
    for (int i = 0; i < 17; i++) press(1, 0, 0, 6);
    chk("to88.pending", int'(pending_temp), 88);
    press(0, 0, 1, 6);
    chk_all("commit88", 88, 88, 1, 0);
    btn_up = 1'b1;
    repeat (7) tick();
    chk("hold.first", int'(pending_temp), 89);
    repeat (19) tick();
    chk("hold.before_rep", int'(pending_temp), 89);
    tick();
    chk("hold.first_rep", int'(pending_temp), 90);
    repeat (33) tick();
    btn_up = 1'b0;
    repeat (12) tick();
    chk_all("hold.sat", 90, 88, 1, 1);
    press(0, 0, 1, 6);
    chk_all("commit90", 90, 90, 1, 0);

    // 5. edit timeout
    btn_down = 1'b1;
    repeat (7) tick();
    btn_down = 1'b0;
    chk_all("to.step", 89, 90, 1, 1);
    repeat (90) tick();
    chk("to.still_edit", int'(editing), 1);
    repeat (20) tick();
    chk_all("to.expired", 90, 90, 1, 0);

    // 6. simultaneous up/down, idle toggle, reset mid-edit
    press(1, 1, 0, 6);
    chk_all("both", 90, 90, 1, 0);
    press(0, 0, 1, 6);
    chk_all("toggle", 90, 90, 0, 0);
    press(0, 1, 0, 6);
    chk_all("edit_again", 89, 90, 0, 1);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    chk_all("reset_edit", 70, 70, 0, 0);

    // Randomized sessions against the model
    m_pend = 70; m_des = 70; m_tset = 0; m_edit = 0;
    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        len = $urandom_range(5, 60);
        press(1, 0, 0, len);
        n = steps_for(len);
        for (int j = 0; j < n; j++) m_step(1);
      end else if (op <= 6) begin
        len = $urandom_range(5, 60);
        press(0, 1, 0, len);
        n = steps_for(len);
        for (int j = 0; j < n; j++) m_step(-1);
      end else if (op == 7) begin
        press(0, 0, 1, $urandom_range(5, 30));
        m_set();
      end else if (op == 8 && m_edit == 0) begin
        press(1, 1, 0, $urandom_range(5, 40));
      end else begin
        repeat (130) tick();
        if (m_edit != 0) begin
          m_pend = m_des; m_edit = 0;
        end
      end
      chk_all($sformatf("rand%0d", k), m_pend, m_des, m_tset, m_edit);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
